// File: rtl/muln_seq_mul.sv
// Word-serial multi-precision unsigned multiplier: y = a * b, one word-by-word partial product per cycle.
// Optional two's-complement mode behind `MULN_SIGNED_EN` (adds sgn input and two correction cycles).
module muln_seq_mul #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef MULN_SIGNED_EN
  input  logic                         sgn,
`endif
  input  logic                         start,
  input  logic [NWORDS*WORD_W-1:0]     a,
  input  logic [NWORDS*WORD_W-1:0]     b,
  output logic                         busy,
  output logic                         done,
  output logic [2*NWORDS*WORD_W-1:0]   y
);

  localparam int OP_W  = NWORDS * WORD_W;
  localparam int ACC_W = 2 * OP_W;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

`ifdef MULN_SIGNED_EN
  typedef enum logic [2:0] {IDLE, MUL, CORR_A, CORR_B, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t             state, state_next;
  logic [OP_W-1:0]    a_reg, b_reg;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [IDX_W-1:0]   i_idx, j_idx;
  logic [WORD_W-1:0]  a_word, b_word;
  logic [2*WORD_W-1:0] prod;
  logic [31:0]        shamt;
  logic               last_step;
  logic               accept;
`ifdef MULN_SIGNED_EN
  logic               sgn_reg;
`endif

  assign last_step = (i_idx == LAST) && (j_idx == LAST);
  assign accept    = ((state == IDLE) || (state == DONE)) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and status outputs; start is only looked at in IDLE/DONE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: state_next = start ? MUL : IDLE;
      MUL: begin
        busy = 1'b1;
        if (last_step) begin
`ifdef MULN_SIGNED_EN
          state_next = sgn_reg ? CORR_A : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef MULN_SIGNED_EN
      CORR_A: begin
        busy       = 1'b1;
        state_next = CORR_B;
      end
      CORR_B: begin
        busy       = 1'b1;
        state_next = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = start ? MUL : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Partial product a_i*b_j lands at word offset i+j; carries ripple through the whole accumulator.
  always_comb begin
    a_word   = a_reg[i_idx*WORD_W +: WORD_W];
    b_word   = b_reg[j_idx*WORD_W +: WORD_W];
    prod     = {{WORD_W{1'b0}}, a_word} * {{WORD_W{1'b0}}, b_word};
    shamt    = (32'(i_idx) + 32'(j_idx)) * 32'(WORD_W);
    acc_next = acc;
    case (state)
      MUL: acc_next = acc + (ACC_W'(prod) << shamt);
`ifdef MULN_SIGNED_EN
      CORR_A: if (a_reg[OP_W-1]) acc_next = acc - {b_reg, {OP_W{1'b0}}};
      CORR_B: if (b_reg[OP_W-1]) acc_next = acc - {a_reg, {OP_W{1'b0}}};
`endif
      default: acc_next = acc;
    endcase
  end

  // Operand capture, index walk (j inner, i outer) and result load on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
      y     <= '0;
`ifdef MULN_SIGNED_EN
      sgn_reg <= 1'b0;
`endif
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
`ifdef MULN_SIGNED_EN
      sgn_reg <= sgn;
`endif
    end else begin
      acc <= acc_next;
      if (state == MUL) begin
        if (j_idx == LAST) begin
          j_idx <= '0;
          i_idx <= (i_idx == LAST) ? '0 : i_idx + 1'b1;
        end else begin
          j_idx <= j_idx + 1'b1;
        end
      end
      if ((state_next == DONE) && (state != DONE)) y <= acc_next;
    end
  end

endmodule

// File: tb/tb_muln_seq_mul.sv
// Directed self-checking bench for muln_seq_mul at WORD_W=16, NWORDS=2.
// Signed-mode vectors are included when `MULN_SIGNED_EN` is defined.
module tb_muln_seq_mul;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] y;
`ifdef MULN_SIGNED_EN
  logic        sgn;
`endif

  int n_cmp;
  int n_fail;

  muln_seq_mul #(.WORD_W(16), .NWORDS(2)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef MULN_SIGNED_EN
    .sgn   (sgn),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge, mid-cycle.
  task automatic applyStimulus(input logic st, input logic [31:0] av, input logic [31:0] bv);
    start = st;
    a     = av;
    b     = bv;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Start at cycle T, check busy through the MUL cycles and done/y at T+lat.
  task automatic runMul(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] expy, input int lat);
    applyStimulus(1'b1, av, bv);
    for (int k = 1; k <= lat; k++) begin
      nextCycle();
      applyStimulus(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      if (k < lat) begin
        checkOutput({tag, " busy"}, 64'(busy), 64'd1);
        checkOutput({tag, " no early done"}, 64'(done), 64'd0);
      end
    end
    checkOutput({tag, " done"}, 64'(done), 64'd1);
    checkOutput({tag, " busy low in DONE"}, 64'(busy), 64'd0);
    checkOutput({tag, " y"}, y, expy);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
`ifdef MULN_SIGNED_EN
    sgn    = 1'b0;
`endif
    applyStimulus(1'b0, '0, '0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset y", y, 64'd0);

    nextCycle();
    runMul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5);
    nextCycle();
    checkOutput("max done pulse one cycle", 64'(done), 64'd0);
    checkOutput("max y holds", y, 64'hFFFF_FFFE_0000_0001);

    nextCycle();
    runMul("carry1", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 5);
    nextCycle();
    runMul("carry2", 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 5);
    nextCycle();
    runMul("small", 32'd7, 32'h0001_0003, 64'h0000_0000_0007_0015, 5);

    // A second start while busy must be ignored entirely.
    nextCycle();
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h1, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("ignored start busy", 64'(busy), 64'd1);
    nextCycle();
    nextCycle();
    checkOutput("ignored start done", 64'(done), 64'd1);
    checkOutput("ignored start y", y, 64'hFFFF_FFFE_0000_0001);
    for (int k = 6; k <= 10; k++) begin
      nextCycle();
      checkOutput("ignored start no second done", 64'(done), 64'd0);
    end

    // Reset in the middle of an operation discards it.
    nextCycle();
    applyStimulus(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset y", y, 64'd0);
    for (int k = 3; k <= 10; k++) begin
      checkOutput("midreset no done", 64'(done), 64'd0);
      nextCycle();
    end

    // Back-to-back: start held in the DONE cycle.
    runMul("b2b first", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 5);
    runMul("b2b second", 32'd3, 32'd5, 64'd15, 5);
    nextCycle();
    runMul("zero", 32'd0, 32'h1234_5678, 64'd0, 5);

`ifdef MULN_SIGNED_EN
    nextCycle();
    sgn = 1'b1;
    runMul("signed", 32'hFFFF_FFFF, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFD, 7);
    nextCycle();
    sgn = 1'b0;
    runMul("signed off", 32'hFFFF_FFFF, 32'h0000_0003, 64'h0000_0002_FFFF_FFFD, 5);
    nextCycle();
    sgn = 1'b1;
    runMul("signed both neg", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd6, 7);
    sgn = 1'b0;
`endif

    nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
